// File: rtl/pwm_multi.sv
// pwm_multi -- multi-channel PWM peripheral on the simple CPU slave bus.
//
// One shared period counter drives CHANNELS compare outputs, each with its
// own polarity. PERIOD and COMP are double-buffered: the CPU writes a shadow
// copy and the active copy picks it up at period wrap (or continuously while
// the block is disabled), so a running waveform never sees a torn period.
//
// Register map (word address bAddr):
//   0      CTRL    [0]=EN, [1]=IRQ enable (PWM_IRQ_EN only), [8+CHANNELS-1:8]=POL
//   1      PERIOD  [WIDTH-1:0] shadow
//   2      STATUS  RO [WIDTH-1:0]=cnt, [31]=wrap flag (PWM_IRQ_EN only, W1C)
//   4+i    COMP[i] [WIDTH-1:0] shadow
//   other  reads 0, writes ignored
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   bSel       peripheral select
//   bWrite     write strobe, qualified by bSel
//   bAddr      word address
//   bWData     write data
//   bRData     combinational read data (0 when not selected)
//   pwmOutput  registered PWM outputs
//   irq        period-wrap interrupt (present only when PWM_IRQ_EN is defined)
//
// Optional feature macro: PWM_IRQ_EN (wrap flag, IRQ enable and irq port).
module pwm_multi #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 8,
   parameter int ADDR_W   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                bSel,
   input  logic                bWrite,
   input  logic [ADDR_W-1:0]   bAddr,
   input  logic [31:0]         bWData,
   output logic [31:0]         bRData,
   output logic [CHANNELS-1:0] pwmOutput
`ifdef PWM_IRQ_EN
   ,
   output logic                irq
`endif
);

   localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_PERIOD = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(2);

   logic                              en;
   logic [CHANNELS-1:0]               pol;
   logic [WIDTH-1:0]                  perShadow, perAct, cnt;
   logic [CHANNELS-1:0][WIDTH-1:0]    compShadow, compAct;
   logic                              wr, wrap, loadAct;
   logic [CHANNELS-1:0]               wrComp;

   assign wr      = bSel & bWrite;
   assign wrap    = en & (cnt == perAct);
   // Actives track shadows continuously while disabled so that enabling
   // starts straight away with the programmed values.
   assign loadAct = wrap | ~en;

   for (genvar g = 0; g < CHANNELS; g++) begin : gComp
      assign wrComp[g] = wr & (bAddr == ADDR_W'(4 + g));
   end

   // Bits of the write bus that no register stores.
   logic unusedWData;
   assign unusedWData = ^bWData;

   // Programming registers (CTRL and shadow copies)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en         <= 1'b0;
         pol        <= '0;
         perShadow  <= '1;
         compShadow <= '0;
      end else begin
         if (wr && bAddr == ADDR_CTRL) begin
            en  <= bWData[0];
            pol <= bWData[8 +: CHANNELS];
         end
         if (wr && bAddr == ADDR_PERIOD) perShadow <= bWData[WIDTH-1:0];
         for (int i = 0; i < CHANNELS; i++)
            if (wrComp[i]) compShadow[i] <= bWData[WIDTH-1:0];
      end
   end

   // Counter, active copies and outputs. A shadow written on the wrap edge
   // is not seen here until the following wrap, since the load samples the
   // pre-edge shadow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perAct    <= '1;
         compAct   <= '0;
         cnt       <= '0;
         pwmOutput <= '0;
      end else begin
         if (loadAct) begin
            perAct  <= perShadow;
            compAct <= compShadow;
         end
         cnt <= loadAct ? '0 : cnt + 1'b1;
         for (int i = 0; i < CHANNELS; i++)
            pwmOutput[i] <= (en & (cnt < compAct[i])) ^ pol[i];
      end
   end

`ifdef PWM_IRQ_EN
   logic irqEn, flag;

   // Wrap sets the flag; writing STATUS with bit31 clears it; set wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         irqEn <= 1'b0;
         flag  <= 1'b0;
      end else begin
         if (wr && bAddr == ADDR_CTRL) irqEn <= bWData[1];
         if (wrap)                                           flag <= 1'b1;
         else if (wr && bAddr == ADDR_STATUS && bWData[31])  flag <= 1'b0;
      end
   end

   assign irq = flag & irqEn;
`endif

   // Combinational read mux; PERIOD/COMP return shadows.
   always_comb begin
      bRData = '0;
      if (bSel) begin
         if (bAddr == ADDR_CTRL) begin
            bRData[0]             = en;
            bRData[8 +: CHANNELS] = pol;
`ifdef PWM_IRQ_EN
            bRData[1]             = irqEn;
`endif
         end
         if (bAddr == ADDR_PERIOD) bRData[WIDTH-1:0] = perShadow;
         if (bAddr == ADDR_STATUS) begin
            bRData[WIDTH-1:0] = cnt;
`ifdef PWM_IRQ_EN
            bRData[31]        = flag;
`endif
         end
         for (int i = 0; i < CHANNELS; i++)
            if (bAddr == ADDR_W'(4 + i)) bRData[WIDTH-1:0] = compShadow[i];
      end
   end

endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;
   localparam int CH = 4;
   localparam int W  = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          bSel = 1'b0, bWrite = 1'b0;
   logic [AW-1:0] bAddr = '0;
   logic [31:0]   bWData = '0;
   logic [31:0]   bRData;
   logic [CH-1:0] pwmOutput;
`ifdef PWM_IRQ_EN
   logic          irq;
   localparam bit IRQ = 1'b1;
`else
   localparam bit IRQ = 1'b0;
`endif

   pwm_multi #(.CHANNELS(CH), .WIDTH(W), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .bSel(bSel), .bWrite(bWrite), .bAddr(bAddr),
      .bWData(bWData), .bRData(bRData), .pwmOutput(pwmOutput)
`ifdef PWM_IRQ_EN
      , .irq(irq)
`endif
   );

   always #5 clk = ~clk;

   int nAssert = 0, nFail = 0;

   // Behavioural model state
   logic          mEn, mIrqEn, mFlag;
   logic [CH-1:0] mPol, mOut;
   int            mPerS, mPerA, mCnt;
   int            mCompS[CH], mCompA[CH];

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void resetModel();
      mEn = 0; mIrqEn = 0; mFlag = 0; mPol = '0; mOut = '0;
      mPerS = (1 << W) - 1; mPerA = (1 << W) - 1; mCnt = 0;
      for (int i = 0; i < CH; i++) begin mCompS[i] = 0; mCompA[i] = 0; end
   endfunction

   function automatic logic [31:0] modelRead(int a);
      logic [31:0] r;
      r = '0;
      case (a)
         0: begin r[0] = mEn; r[1] = mIrqEn; r[8 +: CH] = mPol; end
         1: r = 32'(mPerS);
         2: begin r = 32'(mCnt); r[31] = mFlag; end
         4, 5, 6, 7: r = 32'(mCompS[a-4]);
         default: r = '0;
      endcase
      return r;
   endfunction

   // Expected number of active cycles per period for a channel.
   function automatic int expDuty(int comp, int per, bit p);
      int h;
      h = (comp == 0) ? 0 : (comp > per) ? per + 1 : comp;
      return p ? per + 1 - h : h;
   endfunction

   // Advance the model across one rising edge using the pre-edge bus.
   function automatic void modelStep();
      bit wr, wrap;
      int a;
      wr   = bSel && bWrite;
      a    = int'(bAddr);
      wrap = mEn && (mCnt == mPerA);
      for (int i = 0; i < CH; i++)
         mOut[i] = (mEn && (mCnt < mCompA[i])) ^ mPol[i];
      if (IRQ && wrap) mFlag = 1;
      else if (IRQ && wr && a == 2 && bWData[31]) mFlag = 0;
      mCnt = (!mEn || wrap) ? 0 : mCnt + 1;
      if (!mEn || wrap) begin
         mPerA = mPerS;
         for (int i = 0; i < CH; i++) mCompA[i] = mCompS[i];
      end
      if (wr) begin
         case (a)
            0: begin mEn = bWData[0]; mPol = bWData[8 +: CH]; mIrqEn = IRQ ? bWData[1] : 1'b0; end
            1: mPerS = int'(bWData[W-1:0]);
            4, 5, 6, 7: mCompS[a-4] = int'(bWData[W-1:0]);
            default: ;
         endcase
      end
   endfunction

   task automatic tick();
      modelStep();
      @(posedge clk);
      #1;
      check("pwmOutput", 32'(pwmOutput), 32'(mOut));
`ifdef PWM_IRQ_EN
      check("irq", 32'(irq), 32'(mFlag & mIrqEn));
`endif
      bSel = 0; bWrite = 0;
   endtask

   task automatic wr(int a, logic [31:0] d);
      bSel = 1; bWrite = 1; bAddr = AW'(a); bWData = d;
      tick();
   endtask

   task automatic rdExp(string tag, int a, logic [31:0] exp);
      bSel = 1; bWrite = 0; bAddr = AW'(a);
      #1;
      check(tag, bRData, exp);
      bSel = 0;
   endtask

   task automatic dutyCheck(string tag, int ch, int expHigh);
      int h;
      h = 0;
      for (int k = 0; k < mPerA + 1; k++) begin
         tick();
         h += int'(pwmOutput[ch]);
      end
      check(tag, 32'(h), 32'(expHigh));
   endtask

   initial begin
      int r, a;
      logic [31:0] d;
      resetModel();

      // 1: reset state
      #12;
      check("reset pwmOutput", 32'(pwmOutput), 32'h0);
      rst = 1;
      tick();
      rdExp("reset CTRL", 0, 32'h0);
      rdExp("reset PERIOD", 1, 32'hFF);
      rdExp("reset COMP0", 4, 32'h0);
      rdExp("reset STATUS", 2, 32'h0);
      bAddr = AW'(1); #1;
      check("unselected read", bRData, 32'h0);

      // 2: basic 5/10 duty
      wr(1, 9); wr(4, 5); wr(0, 1);
      for (int k = 0; k < 20; k++) tick();
      dutyCheck("t2 duty ch0", 0, expDuty(5, 9, 0));

      // 3: COMP change mid-period takes effect at next wrap
      for (int k = 0; k < 20 && mCnt != 3; k++) tick();
      rdExp("t3 cnt before write", 2, modelRead(2));
      wr(4, 2);
      rdExp("t3 COMP0 readback", 4, 32'h2);
      tick();
      check("t3 old compare holds", 32'(pwmOutput[0]), 32'h1);
      for (int k = 0; k < 15; k++) tick();
      dutyCheck("t3 new duty ch0", 0, expDuty(2, 9, 0));

      // 4: boundary compares and polarity
      wr(5, 0); wr(6, 20); wr(7, 5); wr(0, 32'h1 | (32'h1 << 11));
      for (int k = 0; k < 25; k++) tick();
      dutyCheck("t4 duty ch1 comp0", 1, expDuty(0, 9, 0));
      dutyCheck("t4 duty ch2 comp>per", 2, expDuty(20, 9, 0));
      dutyCheck("t4 duty ch3 inverted", 3, expDuty(5, 9, 1));

      // 5: disable mid-period, then async reset mid-period
      for (int k = 0; k < 20 && mCnt != 6; k++) tick();
      wr(0, 32'h1 << 11);
      tick();
      rdExp("t5 STATUS after disable", 2, modelRead(2));
      check("t5 outputs equal POL", 32'(pwmOutput), 32'h8);
      wr(0, 32'h1);
      for (int k = 0; k < 4; k++) tick();
      #2 rst = 0;
      #1;
      check("t5 async reset pwmOutput", 32'(pwmOutput), 32'h0);
      resetModel();
      rdExp("t5 reset COMP0", 4, 32'h0);
      #1 rst = 1;
      tick();

      // 6: wrap interrupt
`ifdef PWM_IRQ_EN
      wr(1, 9); wr(4, 5); wr(0, 3);
      for (int k = 0; k < 30 && !mFlag; k++) tick();
      check("t6 irq after wrap", 32'(irq), 32'h1);
      rdExp("t6 STATUS flag", 2, modelRead(2));
      wr(2, 32'h8000_0000);
      check("t6 irq cleared", 32'(irq), 32'h0);
      for (int k = 0; k < 5; k++) tick();
`endif

      // PERIOD=0 boundary: wrap every cycle
      wr(1, 0); wr(4, 1); wr(5, 0); wr(0, 1);
      for (int k = 0; k < 6; k++) tick();
      check("period0 ch0 active", 32'(pwmOutput[0]), 32'h1);
      check("period0 ch1 inactive", 32'(pwmOutput[1]), 32'h0);

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         r = int'($urandom_range(0, 7));
         if (r == 0) begin
            a = int'($urandom_range(0, 9));
            d = $urandom;
            if (a == 1) d = $urandom_range(0, 12);
            if (a >= 4 && a <= 7) d = $urandom_range(0, 14);
            if (a == 0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            wr(a, d);
         end else begin
            a = int'($urandom_range(0, 9));
            rdExp("random read", a, modelRead(a));
            tick();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
